ifu_fetch: RTL and testbench

- Instruction fetch unit; holds the architectural PC and fetches one instruction at a time over a valid/ready instruction-memory port.
- Presents the fetched instruction to decode and waits for the executing stage to commit.
- On commit, selects the next PC: sequential, jump/branch target, or the CSR file's trap/return PC (csrPC: mtvec on ecall, mepc on mret).
- Directly downstream of the CSR file: consumes its csrPC and supplies the pc it latches into mepc.

---
 rtl/ifu_fetch_pkg.sv | 21 ++
 rtl/ifu_npc_sel.sv | 32 +++
 rtl/ifu_fetch.sv | 95 +++++++++
 tb/tb_ifu_fetch.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// Shared constants and types for the instruction fetch unit.
// Next-PC select codes, FSM encoding, trap cause codes.
package ifu_fetch_pkg;

  localparam logic [1:0] NPC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] NPC_SEL_JUMP = 2'b01;
  localparam logic [1:0] NPC_SEL_CSR  = 2'b10;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetchState_e;

  localparam logic [3:0] CAUSE_MISALIGN = 4'd0;
  localparam logic [3:0] CAUSE_ACCESS   = 4'd1;

  localparam logic [31:0] NOP              = 32'h00000013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h80000000;

endpackage

// File: rtl/ifu_npc_sel.sv
// Next-PC mux: sequential, jump target or CSR trap/return PC.
// Also flags a target that is not word aligned.
module ifu_npc_sel
  import ifu_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [1:0]            npcSel,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  input  logic [ADDR_WIDTH-1:0] csrPc,
  output logic [ADDR_WIDTH-1:0] npc,
  output logic                  misaligned
);

  logic [ADDR_WIDTH-1:0] seqPc;

  assign seqPc = pc + ADDR_WIDTH'(4);

  // Reserved select code falls back to sequential
  always_comb begin
    npc = seqPc;
    unique case (npcSel)
      NPC_SEL_JUMP: npc = jumpTarget;
      NPC_SEL_CSR:  npc = csrPc;
      default:      npc = seqPc;
    endcase
  end

  assign misaligned = |npc[1:0];

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC register, one-at-a-time fetch FSM,
// fault capture and completed-fetch counter.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  input  logic                  imem_rsp_err,
  output logic                  imem_rsp_ready,
  output logic                  inst_valid,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  inst_err,
  output logic [3:0]            err_cause,
  input  logic                  commit,
  input  logic [1:0]            npc_sel,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  input  logic [ADDR_WIDTH-1:0] csr_pc,
  output logic [31:0]           fetch_count
);

  fetchState_e           state;
  fetchState_e           stateNext;
  logic [ADDR_WIDTH-1:0] npc;
  logic                  npcMisaligned;
  logic                  rspTake;
  logic                  commitTake;

  ifu_npc_sel #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) uNpcSel (
    .pc        (pc),
    .npcSel    (npc_sel),
    .jumpTarget(jump_target),
    .csrPc     (csr_pc),
    .npc       (npc),
    .misaligned(npcMisaligned)
  );

  assign rspTake    = (state == WAIT) && imem_rsp_valid;
  assign commitTake = (state == HOLD) && commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= REQ;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      REQ:     if (imem_req_ready) stateNext = WAIT;
      WAIT:    if (imem_rsp_valid) stateNext = HOLD;
      HOLD:    if (commit && !npcMisaligned) stateNext = REQ;
      default: stateNext = REQ;
    endcase
  end

  // Misaligned targets never reach memory; the slot becomes a fault
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst        <= DATA_WIDTH'(NOP);
      inst_err    <= 1'b0;
      err_cause   <= CAUSE_MISALIGN;
      fetch_count <= 32'd0;
    end else if (rspTake) begin
      inst        <= imem_rsp_err ? DATA_WIDTH'(NOP) : imem_rsp_data;
      inst_err    <= imem_rsp_err;
      err_cause   <= imem_rsp_err ? CAUSE_ACCESS : CAUSE_MISALIGN;
      fetch_count <= fetch_count + 32'd1;
    end else if (commitTake) begin
      pc <= npc;
      if (npcMisaligned) begin
        inst      <= DATA_WIDTH'(NOP);
        inst_err  <= 1'b1;
        err_cause <= CAUSE_MISALIGN;
      end
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign imem_rsp_ready = (state == WAIT);
  assign inst_valid     = (state == HOLD);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: table of commit vectors plus hand sequences,
// with a queue of expected fetch results checked at decode.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        imem_rsp_ready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_err;
  logic [3:0]  err_cause;
  logic        commit;
  logic [1:0]  npc_sel;
  logic [31:0] jump_target;
  logic [31:0] csr_pc;
  logic [31:0] fetch_count;

  ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .imem_rsp_ready(imem_rsp_ready),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .pc            (pc),
    .inst_err      (inst_err),
    .err_cause     (err_cause),
    .commit        (commit),
    .npc_sel       (npc_sel),
    .jump_target   (jump_target),
    .csr_pc        (csr_pc),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        err;
    logic [3:0]  cause;
  } exp_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] jt;
    logic [31:0] cp;
    int          delay;
    bit          err;
    logic [31:0] expPc;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[10];
  int          total = 0;
  int          bad = 0;
  logic [31:0] modelPc;
  logic [31:0] expCount;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return a ^ 32'h80100093;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doFetch(int delay, bit err);
    exp_t        e;
    exp_t        g;
    logic [31:0] a0;
    bit          stable;
    int          n;
    stable = 1'b1;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    check("reqValid", 32'(imem_req_valid), 32'd1);
    check("rspReadyInReq", 32'(imem_rsp_ready), 32'd0);
    a0 = imem_req_addr;
    check("reqAddr", a0, modelPc);
    repeat (delay) begin
      imem_req_ready = 1'b0;
      step();
      if (imem_req_valid !== 1'b1 || imem_req_addr !== a0) stable = 1'b0;
    end
    if (delay > 0) check("addrStable", 32'(stable), 32'd1);
    imem_req_ready = 1'b1;
    e.pc    = a0;
    e.inst  = err ? NOP : memWord(a0);
    e.err   = err;
    e.cause = err ? 4'd1 : 4'd0;
    sb.push_back(e);
    step();
    imem_req_ready = 1'b0;
    check("rspReadyWait", 32'(imem_rsp_ready), 32'd1);
    check("instValidWait", 32'(inst_valid), 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = memWord(a0);
    imem_rsp_err   = err;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    expCount = expCount + 32'd1;
    check("instValidHold", 32'(inst_valid), 32'd1);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: got empty want entry");
    end else begin
      g = sb.pop_front();
      check("inst", inst, g.inst);
      check("pc", pc, g.pc);
      check("instErr", 32'(inst_err), 32'(g.err));
      check("errCause", 32'(err_cause), 32'(g.cause));
      check("fetchCount", fetch_count, expCount);
    end
  endtask

  task automatic doCommit(logic [1:0] sel, logic [31:0] jt,
                          logic [31:0] cp, logic [31:0] expPc);
    npc_sel     = sel;
    jump_target = jt;
    csr_pc      = cp;
    commit      = 1'b1;
    step();
    commit      = 1'b0;
    npc_sel     = 2'b01;
    jump_target = 32'hDEADBEE1;
    csr_pc      = 32'hDEADBEE2;
    modelPc     = expPc;
    check("commitPc", pc, expPc);
    if (expPc[1:0] != 2'b00) begin
      check("misInstValid", 32'(inst_valid), 32'd1);
      check("misInstErr", 32'(inst_err), 32'd1);
      check("misCause", 32'(err_cause), 32'd0);
      check("misInst", inst, NOP);
      check("misNoReq", 32'(imem_req_valid), 32'd0);
      check("misCount", fetch_count, expCount);
    end else begin
      check("commitInstValid", 32'(inst_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h0, 32'h0, 0, 1'b0, 32'h80000004};
    vecs[1] = '{2'b10, 32'h0, 32'h80001000, 0, 1'b0, 32'h80001000};
    vecs[2] = '{2'b01, 32'h80000102, 32'h0, 0, 1'b0, 32'h80000102};
    vecs[3] = '{2'b10, 32'h0, 32'h80000200, 5, 1'b1, 32'h80000200};
    vecs[4] = '{2'b11, 32'h11111110, 32'h0, 2, 1'b0, 32'h80000204};
    vecs[5] = '{2'b01, 32'hFFFFFFFC, 32'h0, 0, 1'b0, 32'hFFFFFFFC};
    vecs[6] = '{2'b00, 32'h0, 32'h0, 1, 1'b0, 32'h00000000};
    vecs[7] = '{2'b01, 32'h00000001, 32'h0, 0, 1'b0, 32'h00000001};
    vecs[8] = '{2'b00, 32'h0, 32'h0, 0, 1'b0, 32'h00000005};
    vecs[9] = '{2'b10, 32'h0, 32'h80000010, 0, 1'b0, 32'h80000010};

    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_rsp_err   = 1'b0;
    commit         = 1'b0;
    npc_sel        = 2'b00;
    jump_target    = 32'h0;
    csr_pc         = 32'h0;
    expCount       = 32'd0;
    modelPc        = 32'h80000000;
    step();
    step();
    check("rstPc", pc, 32'h80000000);
    check("rstInst", inst, NOP);
    check("rstInstValid", 32'(inst_valid), 32'd0);
    check("rstInstErr", 32'(inst_err), 32'd0);
    check("rstCause", 32'(err_cause), 32'd0);
    check("rstCount", fetch_count, 32'd0);
    rst = 1'b0;

    doFetch(0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      doCommit(vecs[i].sel, vecs[i].jt, vecs[i].cp, vecs[i].expPc);
      if (vecs[i].expPc[1:0] == 2'b00) doFetch(vecs[i].delay, vecs[i].err);
    end

    // commit while in REQ must not move the PC
    doCommit(2'b00, 32'h0, 32'h0, 32'h80000014);
    imem_req_ready = 1'b0;
    npc_sel        = 2'b01;
    jump_target    = 32'h12345678;
    commit         = 1'b1;
    step();
    commit = 1'b0;
    check("commitInReq", imem_req_addr, 32'h80000014);
    doFetch(0, 1'b0);

    // reset while waiting for a response, then a stale response
    doCommit(2'b00, 32'h0, 32'h0, 32'h80000018);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("preRstWait", 32'(imem_rsp_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("midRstPc", pc, 32'h80000000);
    check("midRstCount", fetch_count, 32'd0);
    check("midRstReq", 32'(imem_req_valid), 32'd1);
    step();
    rst            = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0BAD0;
    step();
    step();
    check("staleInstValid", 32'(inst_valid), 32'd0);
    check("staleCount", fetch_count, 32'd0);
    check("staleAddr", imem_req_addr, 32'h80000000);
    check("staleInst", inst, NOP);
    imem_rsp_valid = 1'b0;
    sb.delete();
    expCount = 32'd0;
    modelPc  = 32'h80000000;
    doFetch(0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
